// File: rtl/mips_alu_pkg.sv
// ALU control codes shared by the ALU controller, the ALU and the HI/LO unit.
package mips_alu_pkg;

   localparam int ALU_CTRL_W = 5;

   localparam logic [4:0] ALU_MULT  = 5'b00010;
   localparam logic [4:0] ALU_MFHI  = 5'b01001;
   localparam logic [4:0] ALU_MFLO  = 5'b01010;
   localparam logic [4:0] ALU_MTHI  = 5'b01011;
   localparam logic [4:0] ALU_MTLO  = 5'b01100;
   localparam logic [4:0] ALU_MULTU = 5'b10011;
   localparam logic [4:0] ALU_DIV   = 5'b10100;
   localparam logic [4:0] ALU_DIVU  = 5'b10101;

   // True for every code that touches HI/LO or the multiply/divide engine.
   function automatic logic is_hilo_code(input logic [4:0] code);
      logic hit_s;
      case (code)
         ALU_MULT, ALU_MULTU, ALU_DIV, ALU_DIVU,
         ALU_MTHI, ALU_MTLO, ALU_MFHI, ALU_MFLO: hit_s = 1'b1;
         default:                                hit_s = 1'b0;
      endcase
      return hit_s;
   endfunction

endpackage

// File: rtl/muldiv_iter_r0.sv
// muldiv_iter_r0: unsigned iterative multiply (shift-add) / divide
// (restoring shift-subtract) datapath, one bit per cycle.
// Result layout in acc: multiply -> full product; divide -> {remainder, quotient}.
module muldiv_iter_r0 #(
   parameter int WIDTH = 32,
   parameter int ITER  = WIDTH
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               is_div,
   input  logic [WIDTH-1:0]   op_a,
   input  logic [WIDTH-1:0]   op_b,
   output logic               done,
   output logic [2*WIDTH-1:0] acc
);

   localparam logic [4:0] LAST_CNT = 5'(ITER - 1);

   logic [2*WIDTH-1:0] acc_r;
   logic [WIDTH-1:0]   opb_r;
   logic [4:0]         cnt_r;
   logic               run_r;
   logic               div_r;
   logic [WIDTH:0]     add_s;
   logic [WIDTH:0]     shl_s;
   logic [WIDTH:0]     sub_s;
   logic [2*WIDTH-1:0] step_s;

   // One iteration: conditional add then shift right (multiply), or
   // shift left then trial subtract and restore (divide).
   always_comb begin
      add_s  = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, opb_r};
      shl_s  = acc_r[2*WIDTH-1:WIDTH-1];
      sub_s  = shl_s - {1'b0, opb_r};
      step_s = acc_r;
      if (div_r) begin
         if (!sub_s[WIDTH]) begin
            step_s = {sub_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
         end else begin
            step_s = {shl_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
         end
      end else begin
         if (acc_r[0]) begin
            step_s = {add_s, acc_r[WIDTH-1:1]};
         end else begin
            step_s = {1'b0, acc_r[2*WIDTH-1:1]};
         end
      end
   end

   // Load operands on start, then step once per cycle until the last iteration.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_r <= {(2*WIDTH){1'b0}};
         opb_r <= {WIDTH{1'b0}};
         cnt_r <= 5'd0;
         run_r <= 1'b0;
         div_r <= 1'b0;
      end else if (start) begin
         acc_r <= {{WIDTH{1'b0}}, (is_div ? op_a : op_b)};
         opb_r <= is_div ? op_b : op_a;
         cnt_r <= 5'd0;
         run_r <= 1'b1;
         div_r <= is_div;
      end else if (run_r) begin
         acc_r <= step_s;
         if (cnt_r == LAST_CNT) begin
            cnt_r <= 5'd0;
            run_r <= 1'b0;
         end else begin
            cnt_r <= cnt_r + 5'd1;
         end
      end
   end

   assign done = run_r & (cnt_r == LAST_CNT);
   assign acc  = acc_r;

endmodule

// File: rtl/hilo_unit_r0.sv
// hilo_unit_r0: execute-stage multiply/divide unit owning the HI and LO
// registers; stalls HI/LO instructions while an operation is in flight.
module hilo_unit_r0 #(
   parameter int WIDTH = 32,
   parameter int ITER  = WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             valid_i,
   input  logic [4:0]       ALUCtrl_i,
   input  logic [WIDTH-1:0] rs_i,
   input  logic [WIDTH-1:0] rt_i,
   output logic             stall_o,
   output logic [WIDTH-1:0] result_o,
   output logic             result_valid_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o,
   output logic             busy_o
);

   import mips_alu_pkg::*;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_FIX  = 2'd3
   } state_t;

   state_t             state_r;
   logic [WIDTH-1:0]   hi_r;
   logic [WIDTH-1:0]   lo_r;
   logic [WIDTH-1:0]   rs_keep_r;
   logic               div_r;
   logic               neg_res_r;
   logic               neg_rem_r;
   logic               div_zero_r;

   logic               hilo_s;
   logic               busy_s;
   logic               accept_s;
   logic               start_s;
   logic               start_div_s;
   logic               signed_s;
   logic [WIDTH-1:0]   mag_a_s;
   logic [WIDTH-1:0]   mag_b_s;
   logic               done_s;
   logic [2*WIDTH-1:0] acc_s;
   logic [2*WIDTH-1:0] prod_fix_s;
   logic [WIDTH-1:0]   quot_fix_s;
   logic [WIDTH-1:0]   rem_fix_s;

   // Decode the code, derive stall/accept and the operand magnitudes.
   always_comb begin
      hilo_s      = is_hilo_code(ALUCtrl_i);
      busy_s      = (state_r != ST_IDLE);
      accept_s    = valid_i & hilo_s & ~busy_s;
      start_s     = 1'b0;
      start_div_s = 1'b0;
      signed_s    = 1'b0;
      if (accept_s) begin
         case (ALUCtrl_i)
            ALU_MULT:  begin start_s = 1'b1; signed_s = 1'b1; end
            ALU_MULTU: begin start_s = 1'b1; end
            ALU_DIV:   begin start_s = 1'b1; start_div_s = 1'b1; signed_s = 1'b1; end
            ALU_DIVU:  begin start_s = 1'b1; start_div_s = 1'b1; end
            default:   begin start_s = 1'b0; end
         endcase
      end else begin
         start_s = 1'b0;
      end
      mag_a_s = (signed_s && rs_i[WIDTH-1]) ? -rs_i : rs_i;
      mag_b_s = (signed_s && rt_i[WIDTH-1]) ? -rt_i : rt_i;
   end

   assign busy_o  = busy_s;
   assign stall_o = busy_s & valid_i & hilo_s;
   assign hi_o    = hi_r;
   assign lo_o    = lo_r;

   muldiv_iter_r0 #(
      .WIDTH (WIDTH),
      .ITER  (ITER)
   ) u_iter (
      .clk    (clk),
      .rst    (rst),
      .start  (start_s),
      .is_div (start_div_s),
      .op_a   (mag_a_s),
      .op_b   (mag_b_s),
      .done   (done_s),
      .acc    (acc_s)
   );

   // Sign fix-up of the unsigned engine result; divide-by-zero overrides.
   always_comb begin
      prod_fix_s = neg_res_r ? -acc_s : acc_s;
      if (div_zero_r) begin
         quot_fix_s = {WIDTH{1'b1}};
         rem_fix_s  = rs_keep_r;
      end else begin
         quot_fix_s = neg_res_r ? -acc_s[WIDTH-1:0] : acc_s[WIDTH-1:0];
         rem_fix_s  = neg_rem_r ? -acc_s[2*WIDTH-1:WIDTH] : acc_s[2*WIDTH-1:WIDTH];
      end
   end

   // MFHI/MFLO read data, valid only in the accepting cycle.
   always_comb begin
      result_valid_o = 1'b0;
      result_o       = {WIDTH{1'b0}};
      if (accept_s && !rst) begin
         case (ALUCtrl_i)
            ALU_MFHI: begin result_valid_o = 1'b1; result_o = hi_r; end
            ALU_MFLO: begin result_valid_o = 1'b1; result_o = lo_r; end
            default:  begin result_valid_o = 1'b0; result_o = {WIDTH{1'b0}}; end
         endcase
      end else begin
         result_valid_o = 1'b0;
         result_o       = {WIDTH{1'b0}};
      end
   end

   // Control FSM plus HI/LO registers: accept, iterate, fix up, write back.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= ST_IDLE;
         hi_r       <= {WIDTH{1'b0}};
         lo_r       <= {WIDTH{1'b0}};
         rs_keep_r  <= {WIDTH{1'b0}};
         div_r      <= 1'b0;
         neg_res_r  <= 1'b0;
         neg_rem_r  <= 1'b0;
         div_zero_r <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start_s) begin
                  state_r    <= start_div_s ? ST_DIV : ST_MUL;
                  div_r      <= start_div_s;
                  neg_res_r  <= signed_s & (rs_i[WIDTH-1] ^ rt_i[WIDTH-1]);
                  neg_rem_r  <= signed_s & rs_i[WIDTH-1];
                  div_zero_r <= (rt_i == {WIDTH{1'b0}});
                  rs_keep_r  <= rs_i;
               end else if (accept_s && (ALUCtrl_i == ALU_MTHI)) begin
                  hi_r <= rs_i;
               end else if (accept_s && (ALUCtrl_i == ALU_MTLO)) begin
                  lo_r <= rs_i;
               end
            end
            ST_MUL, ST_DIV: begin
               if (done_s) begin
                  state_r <= ST_FIX;
               end
            end
            ST_FIX: begin
               if (div_r) begin
                  hi_r <= rem_fix_s;
                  lo_r <= quot_fix_s;
               end else begin
                  hi_r <= prod_fix_s[2*WIDTH-1:WIDTH];
                  lo_r <= prod_fix_s[WIDTH-1:0];
               end
               state_r <= ST_IDLE;
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hilo_unit_r0.sv
// Self-checking bench for hilo_unit_r0: directed vectors plus randomized
// mult/div checked against a 64-bit arithmetic reference model.
module tb_hilo_unit_r0;

   localparam logic [4:0] C_MULT  = 5'b00010;
   localparam logic [4:0] C_MFHI  = 5'b01001;
   localparam logic [4:0] C_MFLO  = 5'b01010;
   localparam logic [4:0] C_MTHI  = 5'b01011;
   localparam logic [4:0] C_MTLO  = 5'b01100;
   localparam logic [4:0] C_MULTU = 5'b10011;
   localparam logic [4:0] C_DIV   = 5'b10100;
   localparam logic [4:0] C_DIVU  = 5'b10101;
   localparam logic [4:0] C_ADD   = 5'b00000;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid_i;
   logic [4:0]  ALUCtrl_i;
   logic [31:0] rs_i, rt_i;
   logic        stall_o, result_valid_o, busy_o;
   logic [31:0] result_o, hi_o, lo_o;

   int checks = 0;
   int errors = 0;

   hilo_unit_r0 #(.WIDTH(32), .ITER(32)) dut (
      .clk(clk), .rst(rst), .valid_i(valid_i), .ALUCtrl_i(ALUCtrl_i),
      .rs_i(rs_i), .rt_i(rt_i), .stall_o(stall_o), .result_o(result_o),
      .result_valid_o(result_valid_o), .hi_o(hi_o), .lo_o(lo_o), .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic is_hilo(input logic [4:0] c);
      return (c == C_MULT) || (c == C_MULTU) || (c == C_DIV) || (c == C_DIVU) ||
             (c == C_MTHI) || (c == C_MTLO) || (c == C_MFHI) || (c == C_MFLO);
   endfunction

   // Reference: plain 64-bit arithmetic plus the architectural special cases.
   function automatic void ref_muldiv(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] hi, output logic [31:0] lo);
      longint sa, sb, q, r;
      logic [63:0] p;
      sa = $signed(a);
      sb = $signed(b);
      hi = 32'h0;
      lo = 32'h0;
      if (c == C_MULT) begin
         p = sa * sb; hi = p[63:32]; lo = p[31:0];
      end else if (c == C_MULTU) begin
         p = {32'h0, a} * {32'h0, b}; hi = p[63:32]; lo = p[31:0];
      end else if (b == 32'h0) begin
         lo = 32'hFFFFFFFF; hi = a;
      end else if (c == C_DIV) begin
         if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
            lo = 32'h80000000; hi = 32'h0;
         end else begin
            q = sa / sb; r = sa % sb; lo = q[31:0]; hi = r[31:0];
         end
      end else begin
         lo = a / b; hi = a % b;
      end
   endfunction

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
      valid_i = v; ALUCtrl_i = c; rs_i = a; rt_i = b;
      #1;
   endtask

   // Present a mult/div, then count cycles with busy high (bounded).
   task automatic run_muldiv(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b, output int busy_n);
      drive(1'b1, c, a, b);
      next_cycle();
      drive(1'b0, C_ADD, 32'h0, 32'h0);
      busy_n = 0;
      while (busy_o === 1'b1 && busy_n < 100) begin
         busy_n++;
         next_cycle();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(1'b0, C_ADD, 32'h0, 32'h0);
      next_cycle();
      next_cycle();
      rst = 1'b0;
      #1;
      checks++; if (hi_o !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h want 0", hi_o); end
      checks++; if (lo_o !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h want 0", lo_o); end
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_o); end
      checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall_o); end
      checks++; if (result_valid_o !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b want 0", result_valid_o); end
      checks++; if (result_o !== 32'h0) begin errors++; $display("FAIL reset_result: got %h want 0", result_o); end
   endtask

   task automatic test_directed();
      logic [4:0]  tc [9] = '{C_MULT, C_MULTU, C_DIV, C_DIVU, C_DIV, C_DIV, C_MULT, C_DIV, C_DIVU};
      logic [31:0] ta [9] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'h7, 32'h80000000,
                              32'hFFFFFFF7, 32'h80000000, 32'h7, 32'hFFFFFFFF};
      logic [31:0] tb [9] = '{32'h5, 32'hFFFFFFFF, 32'h2, 32'h0, 32'hFFFFFFFF,
                              32'h0, 32'h80000000, 32'hFFFFFFFE, 32'h10};
      logic [31:0] eh [9] = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h7, 32'h0,
                              32'hFFFFFFF7, 32'h40000000, 32'h1, 32'hF};
      logic [31:0] el [9] = '{32'hFFFFFFF1, 32'h1, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000,
                              32'hFFFFFFFF, 32'h0, 32'hFFFFFFFD, 32'h0FFFFFFF};
      int n;
      for (int i = 0; i < 9; i++) begin
         run_muldiv(tc[i], ta[i], tb[i], n);
         checks++; if (n != 33) begin errors++; $display("FAIL dir%0d_busy_cycles: got %0d want 33", i, n); end
         checks++; if (hi_o !== eh[i]) begin errors++; $display("FAIL dir%0d_hi: got %h want %h", i, hi_o, eh[i]); end
         checks++; if (lo_o !== el[i]) begin errors++; $display("FAIL dir%0d_lo: got %h want %h", i, lo_o, el[i]); end
      end
   endtask

   task automatic test_random();
      logic [4:0]  codes [4] = '{C_MULT, C_MULTU, C_DIV, C_DIVU};
      logic [4:0]  c;
      logic [31:0] a, b, eh, el;
      int n, mode;
      for (int i = 0; i < 30; i++) begin
         c = codes[$urandom_range(0, 3)];
         a = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
         mode = $urandom_range(0, 7);
         if (mode == 0)      b = 32'h0;
         else if (mode == 1) b = $urandom_range(1, 9);
         else if (mode == 2) b = 32'hFFFFFFFF;
         else                b = $urandom;
         ref_muldiv(c, a, b, eh, el);
         run_muldiv(c, a, b, n);
         checks++; if (n != 33) begin errors++; $display("FAIL rnd%0d_busy_cycles: got %0d want 33", i, n); end
         checks++; if (hi_o !== eh) begin errors++; $display("FAIL rnd%0d_hi code=%b a=%h b=%h: got %h want %h", i, c, a, b, hi_o, eh); end
         checks++; if (lo_o !== el) begin errors++; $display("FAIL rnd%0d_lo code=%b a=%h b=%h: got %h want %h", i, c, a, b, lo_o, el); end
      end
   endtask

   task automatic test_mf_after_mult();
      int stalls, bad;
      drive(1'b1, C_MULT, 32'h2, 32'h3);
      next_cycle();
      drive(1'b1, C_MFLO, 32'h0, 32'h0);
      stalls = 0; bad = 0;
      while (stall_o === 1'b1 && stalls < 100) begin
         stalls++;
         if (result_valid_o !== 1'b0) bad++;
         next_cycle();
      end
      checks++; if (stalls != 33) begin errors++; $display("FAIL mf_stall_cycles: got %0d want 33", stalls); end
      checks++; if (bad != 0) begin errors++; $display("FAIL mf_rvalid_while_stalled: got %0d pulses want 0", bad); end
      checks++; if (result_valid_o !== 1'b1) begin errors++; $display("FAIL mflo_rvalid: got %b want 1", result_valid_o); end
      checks++; if (result_o !== 32'h6) begin errors++; $display("FAIL mflo_data: got %h want 6", result_o); end
      next_cycle();
      drive(1'b1, C_MFHI, 32'h0, 32'h0);
      checks++; if (result_valid_o !== 1'b1) begin errors++; $display("FAIL mfhi_rvalid: got %b want 1", result_valid_o); end
      checks++; if (result_o !== 32'h0) begin errors++; $display("FAIL mfhi_data: got %h want 0", result_o); end
      next_cycle();
      drive(1'b0, C_ADD, 32'h0, 32'h0);
   endtask

   task automatic test_back_to_back();
      int stalls, n;
      drive(1'b1, C_MULTU, 32'h00010000, 32'h00030000);
      next_cycle();
      drive(1'b1, C_DIVU, 32'd100, 32'd7);
      stalls = 0;
      while (stall_o === 1'b1 && stalls < 100) begin
         stalls++;
         next_cycle();
      end
      checks++; if (stalls != 33) begin errors++; $display("FAIL b2b_stall_cycles: got %0d want 33", stalls); end
      checks++; if (hi_o !== 32'h3 || lo_o !== 32'h0) begin errors++; $display("FAIL b2b_first_result: got %h_%h want 00000003_00000000", hi_o, lo_o); end
      next_cycle();
      drive(1'b0, C_ADD, 32'h0, 32'h0);
      n = 0;
      while (busy_o === 1'b1 && n < 100) begin
         n++;
         next_cycle();
      end
      checks++; if (n != 33) begin errors++; $display("FAIL b2b_second_busy: got %0d want 33", n); end
      checks++; if (hi_o !== 32'd2 || lo_o !== 32'd14) begin errors++; $display("FAIL b2b_second_result: got %h_%h want 00000002_0000000e", hi_o, lo_o); end
   endtask

   task automatic test_mthi_mtlo();
      int stalls;
      drive(1'b1, C_MTHI, 32'h12345678, 32'h0);
      checks++; if (stall_o !== 1'b0 || result_valid_o !== 1'b0) begin errors++; $display("FAIL mthi_accept: stall=%b rvalid=%b want 0 0", stall_o, result_valid_o); end
      next_cycle();
      drive(1'b1, C_MFHI, 32'h0, 32'h0);
      checks++; if (hi_o !== 32'h12345678) begin errors++; $display("FAIL mthi_hi: got %h want 12345678", hi_o); end
      checks++; if (result_o !== 32'h12345678 || result_valid_o !== 1'b1) begin errors++; $display("FAIL mthi_mfhi: got %h/%b want 12345678/1", result_o, result_valid_o); end
      next_cycle();
      drive(1'b1, C_MTLO, 32'hCAFEF00D, 32'h0);
      next_cycle();
      drive(1'b1, C_MFLO, 32'h0, 32'h0);
      checks++; if (result_o !== 32'hCAFEF00D || lo_o !== 32'hCAFEF00D) begin errors++; $display("FAIL mtlo_mflo: got %h/%h want cafef00d", result_o, lo_o); end
      next_cycle();
      drive(1'b1, C_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF);
      next_cycle();
      drive(1'b1, C_MTHI, 32'hA5A5A5A5, 32'h0);
      stalls = 0;
      while (stall_o === 1'b1 && stalls < 100) begin
         stalls++;
         next_cycle();
      end
      checks++; if (stalls != 33) begin errors++; $display("FAIL mthi_busy_stall: got %0d want 33", stalls); end
      checks++; if (hi_o !== 32'h0 || lo_o !== 32'h1) begin errors++; $display("FAIL mthi_busy_inflight: got %h_%h want 00000000_00000001", hi_o, lo_o); end
      next_cycle();
      drive(1'b0, C_ADD, 32'h0, 32'h0);
      checks++; if (hi_o !== 32'hA5A5A5A5 || lo_o !== 32'h1) begin errors++; $display("FAIL mthi_after_busy: got %h_%h want a5a5a5a5_00000001", hi_o, lo_o); end
   endtask

   task automatic test_non_hilo();
      int bad, n, guard;
      logic [4:0] c;
      logic [31:0] h0, l0;
      drive(1'b1, C_MULT, 32'd7, 32'd9);
      next_cycle();
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         c = C_ADD;
         guard = 0;
         if (i > 0) begin
            c = 5'($urandom_range(0, 31));
            while (is_hilo(c) && guard < 50) begin c = 5'($urandom_range(0, 31)); guard++; end
            if (is_hilo(c)) c = C_ADD;
         end
         drive(1'b1, c, $urandom, $urandom);
         if (stall_o !== 1'b0 || result_valid_o !== 1'b0 || busy_o !== 1'b1) bad++;
         next_cycle();
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL nonhilo_under_busy: got %0d bad cycles want 0", bad); end
      drive(1'b0, C_ADD, 32'h0, 32'h0);
      n = 0;
      while (busy_o === 1'b1 && n < 100) begin n++; next_cycle(); end
      checks++; if (hi_o !== 32'h0 || lo_o !== 32'd63) begin errors++; $display("FAIL nonhilo_mult_result: got %h_%h want 00000000_0000003f", hi_o, lo_o); end
      h0 = hi_o; l0 = lo_o;
      for (int i = 0; i < 6; i++) begin
         c = 5'($urandom_range(0, 31));
         if (is_hilo(c)) c = C_ADD;
         drive(1'b1, c, $urandom, $urandom);
         next_cycle();
      end
      drive(1'b0, C_ADD, 32'h0, 32'h0);
      checks++; if (hi_o !== h0 || lo_o !== l0 || busy_o !== 1'b0) begin errors++; $display("FAIL nonhilo_idle_nochange: got %h_%h busy=%b want %h_%h busy=0", hi_o, lo_o, busy_o, h0, l0); end
   endtask

   task automatic test_reset_mid();
      int n;
      drive(1'b1, C_MTHI, 32'hFFFF0000, 32'h0);
      next_cycle();
      drive(1'b1, C_DIV, 32'd100, 32'd3);
      next_cycle();
      drive(1'b0, C_ADD, 32'h0, 32'h0);
      repeat (9) next_cycle();
      checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before: got %b want 1", busy_o); end
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
      #1;
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy_o); end
      checks++; if (hi_o !== 32'h0 || lo_o !== 32'h0) begin errors++; $display("FAIL rstmid_hilo: got %h_%h want 0_0", hi_o, lo_o); end
      run_muldiv(C_MULT, 32'd4, 32'd4, n);
      checks++; if (n != 33) begin errors++; $display("FAIL rstmid_mult_busy: got %0d want 33", n); end
      checks++; if (lo_o !== 32'd16 || hi_o !== 32'h0) begin errors++; $display("FAIL rstmid_mult: got %h_%h want 00000000_00000010", hi_o, lo_o); end
   endtask

   initial begin
      rst = 1'b1;
      valid_i = 1'b0; ALUCtrl_i = C_ADD; rs_i = 32'h0; rt_i = 32'h0;
      test_reset();
      test_directed();
      test_random();
      test_mf_after_mult();
      test_back_to_back();
      test_mthi_mtlo();
      test_non_hilo();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
